// File: rtl/systolic_feed_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : systolic_feed_ctrl
// Description : Skewed read scheduler for the per-row systolic-array input
//               FIFOs; stalls the whole wavefront on an empty scheduled row.
// Revision    : 1.0
// ============================================================================
module systolic_feed_ctrl #(
    parameter int ROWS      = 4,
    parameter int LEN_W     = 8,
    parameter int DRAIN_CYC = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic [ROWS-1:0]  fifo_empty,
    output logic [ROWS-1:0]  fifo_rd_en,
    output logic [ROWS-1:0]  row_valid,
    output logic             array_en,
    output logic             busy,
    output logic             done
);

    localparam int c_TW = LEN_W + $clog2(ROWS) + 1;
    localparam int c_DW = $clog2(DRAIN_CYC) + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          r_state;
    logic [c_TW-1:0] r_t;
    logic [c_TW-1:0] r_len;
    logic [c_DW-1:0] r_drain;
    logic [c_TW-1:0] w_last_t;
    logic [ROWS-1:0] w_sched;
    logic            w_stall;
    logic            w_run_go;

    // Final step index is len+ROWS-2; r_len is never 0 while in RUN.
    assign w_last_t = r_len + c_TW'(ROWS - 1) - c_TW'(1);

    generate
        for (genvar r = 0; r < ROWS; r++) begin : g_sched
            assign w_sched[r] = (r_t >= c_TW'(r)) && (r_t < c_TW'(r) + r_len);
        end
    endgenerate

    assign w_stall    = |(w_sched & fifo_empty);
    assign w_run_go   = (r_state == S_RUN) && !w_stall;
    assign fifo_rd_en = w_run_go ? w_sched : '0;
    assign busy       = (r_state != S_IDLE);
    assign done       = (r_state == S_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_t       <= '0;
            r_len     <= '0;
            r_drain   <= '0;
            row_valid <= '0;
            array_en  <= 1'b0;
        end else begin
            row_valid <= fifo_rd_en;
            array_en  <= w_run_go || (r_state == S_DRAIN);
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_len <= c_TW'(len);
                        r_t   <= '0;
                        if (len != '0) begin
                            r_state <= S_RUN;
                        end else begin
                            r_state <= S_DONE;
                        end
                    end
                end
                S_RUN: begin
                    if (!w_stall) begin
                        if (r_t == w_last_t) begin
                            r_state <= S_DRAIN;
                            r_drain <= c_DW'(DRAIN_CYC - 1);
                        end else begin
                            r_t <= r_t + c_TW'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    if (r_drain == '0) begin
                        r_state <= S_DONE;
                    end else begin
                        r_drain <= r_drain - c_DW'(1);
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_systolic_feed_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_systolic_feed_ctrl
// Description : Directed and randomized bench for systolic_feed_ctrl against
//               a step-list reference model.
// Revision    : 1.0
// ============================================================================
module tb_systolic_feed_ctrl;

    localparam int ROWS      = 4;
    localparam int LEN_W     = 8;
    localparam int DRAIN_CYC = 8;

    typedef enum int {M_IDLE, M_RUN, M_DRAIN, M_DONE} mode_t;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic [LEN_W-1:0] len = '0;
    logic [ROWS-1:0]  fifo_empty = '0;
    logic [ROWS-1:0]  fifo_rd_en;
    logic [ROWS-1:0]  row_valid;
    logic             array_en;
    logic             busy;
    logic             done;

    always #5 clk = ~clk;

    systolic_feed_ctrl #(
        .ROWS      (ROWS),
        .LEN_W     (LEN_W),
        .DRAIN_CYC (DRAIN_CYC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .len        (len),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .row_valid  (row_valid),
        .array_en   (array_en),
        .busy       (busy),
        .done       (done)
    );

    int n_checks = 0;
    int n_pass   = 0;

    mode_t           m_mode = M_IDLE;
    int              m_step, m_len, m_drain_left, m_cyc, m_accept, m_stalls;
    logic [ROWS-1:0] m_prev_rd = '0;
    logic            m_prev_aen = 1'b0;
    int              rd_cnt [ROWS];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    // Row r consumes elements during steps r .. r+len-1.
    function automatic logic [ROWS-1:0] mask_of(input int step, input int l);
        logic [ROWS-1:0] m;
        m = '0;
        for (int r = 0; r < ROWS; r++) m[r] = (step >= r) && (step < r + l);
        return m;
    endfunction

    task automatic model_reset();
        m_mode     = M_IDLE;
        m_prev_rd  = '0;
        m_prev_aen = 1'b0;
        for (int r = 0; r < ROWS; r++) rd_cnt[r] = 0;
    endtask

    task automatic eval();
        logic [ROWS-1:0] mask, exp_rd;
        logic            stall;
        mask   = (m_mode == M_RUN) ? mask_of(m_step, m_len) : '0;
        stall  = |(mask & fifo_empty);
        exp_rd = (m_mode == M_RUN && !stall) ? mask : '0;
        chk("rd_en", 32'(fifo_rd_en), 32'(exp_rd));
        chk("row_valid", 32'(row_valid), 32'(m_prev_rd));
        chk("array_en", 32'(array_en), 32'(m_prev_aen));
        chk("busy", 32'(busy), 32'(m_mode != M_IDLE));
        chk("done", 32'(done), 32'(m_mode == M_DONE));
        chk("no_empty_read", 32'(fifo_rd_en & fifo_empty), 32'd0);
        for (int r = 0; r < ROWS; r++) if (fifo_rd_en[r] === 1'b1) rd_cnt[r]++;
        if (m_mode == M_DONE) begin
            for (int r = 0; r < ROWS; r++) chk("reads_per_row", rd_cnt[r], m_len);
            chk("done_latency", m_cyc - m_accept,
                (m_len == 0) ? 1 : m_len + ROWS + m_stalls + DRAIN_CYC);
        end
        m_prev_rd  = exp_rd;
        m_prev_aen = (m_mode == M_RUN && !stall) || (m_mode == M_DRAIN);
        if (rst) begin
            model_reset();
        end else begin
            case (m_mode)
                M_IDLE: if (start) begin
                    m_accept = m_cyc;
                    m_stalls = 0;
                    m_len    = int'(len);
                    m_step   = 0;
                    for (int r = 0; r < ROWS; r++) rd_cnt[r] = 0;
                    m_mode   = (m_len != 0) ? M_RUN : M_DONE;
                end
                M_RUN: begin
                    if (stall) m_stalls++;
                    else if (m_step == m_len + ROWS - 2) begin
                        m_mode       = M_DRAIN;
                        m_drain_left = DRAIN_CYC;
                    end else m_step++;
                end
                M_DRAIN: begin
                    m_drain_left--;
                    if (m_drain_left == 0) m_mode = M_DONE;
                end
                default: m_mode = M_IDLE;
            endcase
        end
        m_cyc++;
    endtask

    task automatic cycle(input logic st, input int ln, input logic [ROWS-1:0] emp);
        @(posedge clk);
        #1;
        start      = st;
        len        = LEN_W'(ln);
        fifo_empty = emp;
        @(negedge clk);
        eval();
    endtask

    // Raise rst between clock edges and expect every output to clear at once.
    task automatic async_reset_check();
        #2;
        rst = 1'b1;
        #1;
        chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        chk("rst_row_valid", 32'(row_valid), 32'd0);
        chk("rst_array_en", 32'(array_en), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        model_reset();
        repeat (3) cycle(1'b0, 0, '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    logic [ROWS-1:0] seen [24];
    logic [3:0]      exp_len3 [6] = '{4'h1, 4'h3, 4'h7, 4'hE, 4'hC, 4'h8};
    logic [3:0]      exp_len2 [5] = '{4'h1, 4'h3, 4'h6, 4'hC, 4'h8};

    initial begin
        m_cyc = 0;
        model_reset();
        async_reset_check();

        for (int k = 0; k < 16; k++) begin
            cycle(k == 0, 3, '0);
            seen[k] = fifo_rd_en;
        end
        for (int i = 0; i < 6; i++) chk("seq_len3", 32'(seen[i+1]), 32'(exp_len3[i]));

        for (int k = 0; k < 19; k++)
            cycle(k == 0, 3, (k >= 3 && k <= 5) ? 4'b0100 : 4'b0000);

        for (int k = 0; k < 16; k++) begin
            cycle(k == 0, 3, (k >= 1 && k <= 3) ? 4'b1000 : 4'b0000);
            seen[k] = fifo_rd_en;
        end
        for (int i = 0; i < 6; i++) chk("seq_unsched_empty", 32'(seen[i+1]), 32'(exp_len3[i]));

        for (int k = 0; k < 3; k++) cycle(k == 0, 0, '0);
        for (int k = 0; k < 20; k++) cycle(k == 0 || k == 4 || k == 9, (k == 0) ? 5 : 2, '0);

        for (int k = 0; k < 5; k++) cycle(k == 0, 3, '0);
        async_reset_check();
        for (int k = 0; k < 16; k++) begin
            cycle(k == 0, 2, '0);
            seen[k] = fifo_rd_en;
        end
        for (int i = 0; i < 5; i++) chk("seq_after_rst", 32'(seen[i+1]), 32'(exp_len2[i]));

        for (int tile = 0; tile < 41; tile++) begin
            int ln;
            int k;
            if (tile == 40) ln = 255;
            else ln = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 12));
            k = 0;
            do begin
                logic [ROWS-1:0] emp;
                for (int r = 0; r < ROWS; r++) emp[r] = ($urandom_range(0, 3) == 0);
                cycle(k == 0 || $urandom_range(0, 15) == 0,
                      (k == 0) ? ln : int'($urandom_range(0, 20)), emp);
                k++;
                if (k > 5000) begin
                    chk("tile_timeout", 32'd1, 32'd0);
                    break;
                end
            end while (m_mode != M_IDLE);
            repeat ($urandom_range(0, 2)) cycle(1'b0, 0, '0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
